// File: rtl/mdu_iter_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mdu_iter_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_SIGN = 2'd2
  } mdu_state_e;

  // Per-operation context captured at start and consumed at commit.
  typedef struct packed {
    logic is_div;
    logic res_neg;
    logic rem_neg;
    logic div_zero;
  } mdu_ctx_t;

endpackage

// File: rtl/mdu_iter_step.sv
// One iteration of the multiply (shift-add) or restoring divide (shift-subtract) datapath.
module mdu_step
  import mdu_iter_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] m_i,
  input  logic             is_div_i,
  output logic [WIDTH-1:0] acc_c_o,
  output logic [WIDTH-1:0] q_c_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  always_comb begin
    sum     = {1'b0, acc_i} + (q_i[0] ? {1'b0, m_i} : '0);
    shifted = {acc_i, q_i[WIDTH-1]};
    // When the trial subtract succeeds the result is below m, so WIDTH bits suffice.
    diff    = shifted[WIDTH-1:0] - m_i;
    acc_c_o = sum[WIDTH:1];
    q_c_o   = {sum[0], q_i[WIDTH-1:1]};
    if (is_div_i) begin
      if (shifted >= {1'b0, m_i}) begin
        acc_c_o = diff;
        q_c_o   = {q_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_c_o = shifted[WIDTH-1:0];
        q_c_o   = {q_i[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO pair; 33-cycle latency per op.
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  mdu_state_e       state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mdu_ctx_t         ctx_q, ctx_d;

  mdu_op_e          op_e;
  logic             op_signed_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c;
  logic [WIDTH-1:0] step_acc_c, step_q_c;
  logic [2*WIDTH-1:0] prod_c;

  assign op_e        = mdu_op_e'(op);
  assign op_signed_c = (op_e == MDU_MULT) || (op_e == MDU_DIV);
  assign a_mag_c     = (op_signed_c && a[WIDTH-1]) ? -a : a;
  assign b_mag_c     = (op_signed_c && b[WIDTH-1]) ? -b : b;
  assign prod_c      = ctx_q.res_neg ? -{acc_q, q_q} : {acc_q, q_q};

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .acc_i    (acc_q),
    .q_i      (q_q),
    .m_i      (m_q),
    .is_div_i (ctx_q.is_div),
    .acc_c_o  (step_acc_c),
    .q_c_o    (step_q_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MDU_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      m_q     <= '0;
      a_q     <= '0;
      cnt_q   <= '0;
      ctx_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      m_q     <= m_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      ctx_q   <= ctx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    acc_d   = acc_q;
    q_d     = q_q;
    m_d     = m_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    ctx_d   = ctx_q;

    unique case (state_q)
      MDU_IDLE: begin
        if (start) begin
          case (op_e)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
              ctx_d.is_div   = (op_e == MDU_DIV) || (op_e == MDU_DIVU);
              ctx_d.res_neg  = op_signed_c && (a[WIDTH-1] ^ b[WIDTH-1]);
              ctx_d.rem_neg  = op_signed_c && a[WIDTH-1];
              ctx_d.div_zero = ctx_d.is_div && (b == '0);
              // Multiply walks the multiplier through q; divide walks the dividend.
              q_d     = ctx_d.is_div ? a_mag_c : b_mag_c;
              m_d     = ctx_d.is_div ? b_mag_c : a_mag_c;
              acc_d   = '0;
              a_d     = a;
              cnt_d   = '0;
              busy_d  = 1'b1;
              state_d = MDU_CALC;
            end
            MDU_MTHI: hi_d = a;
            MDU_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      MDU_CALC: begin
        acc_d = step_acc_c;
        q_d   = step_q_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = MDU_SIGN;
      end
      MDU_SIGN: begin
        if (ctx_q.div_zero) begin
          lo_d = '1;
          hi_d = a_q;
        end else if (ctx_q.is_div) begin
          lo_d = ctx_q.res_neg ? -q_q : q_q;
          hi_d = ctx_q.rem_neg ? -acc_q : acc_q;
        end else begin
          hi_d = prod_c[2*WIDTH-1:WIDTH];
          lo_d = prod_c[WIDTH-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = MDU_IDLE;
      end
      default: state_d = MDU_IDLE;
    endcase

    // Squash overrides everything, including an MT write or the final commit.
    if (flush) begin
      state_d = MDU_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter.
module tb_mdu_iter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests = 0;
  int n_fail  = 0;

  mdu_iter dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op and wait (bounded) for done; lat is edges from start sample to done.
  task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                        output int lat);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  int lat;
  int ndone;
  logic [31:0] hold_hi, hold_lo;

  initial begin
    rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0; flush = 1'b0;
    #23;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // MULTU max*max, with exact latency
    @(posedge clk); #1;
    start = 1'b1; op = 3'd1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    check("multu_busy_e0", 64'(busy), 64'd1);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 16) begin
        check("multu_hi_stable", 64'(hi), 64'd0);
        check("multu_lo_stable", 64'(lo), 64'd0);
      end
      if (k == 32) check("multu_busy_e32", 64'({busy, done}), 64'b10);
      if (done) begin
        lat = k;
        break;
      end
    end
    check("multu_lat", 64'(lat), 64'd33);
    check("multu_busy_at_done", 64'(busy), 64'd0);
    check("multu_prod", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    @(posedge clk); #1;
    check("multu_done_pulse", 64'(done), 64'd0);

    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, lat);
    check("mult_lat", 64'(lat), 64'd33);
    check("mult_prod", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, lat);
    check("div_neg_lat", 64'(lat), 64'd33);
    check("div_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    run_op(3'd3, 32'd100, 32'd7, lat);
    check("divu_hilo", {hi, lo}, {32'd2, 32'd14});

    run_op(3'd2, 32'h0000_1234, 32'd0, lat);
    check("div0_lat", 64'(lat), 64'd33);
    check("div0_hilo", {hi, lo}, {32'h0000_1234, 32'hFFFF_FFFF});

    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    check("div_ovf_hilo", {hi, lo}, {32'd0, 32'h8000_0000});

    // Second start during DIVU is ignored
    @(posedge clk); #1;
    start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; lat = -1;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (lat < 0) lat = k;
      end
      if (k == 10) begin
        start = 1'b1; op = 3'd1; a = 32'd5; b = 32'd5;
      end
      if (k == 11) start = 1'b0;
    end
    check("ign_ndone", 64'(ndone), 64'd1);
    check("ign_lat", 64'(lat), 64'd33);
    check("ign_hilo", {hi, lo}, {32'd1, 32'd333});

    // Flush mid-operation
    @(posedge clk); #1;
    start = 1'b1; op = 3'd3; a = 32'd50; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", 64'({busy, done}), 64'b00);
    ndone = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    check("flush_no_done", 64'(ndone), 64'd0);
    check("flush_hilo", {hi, lo}, {32'd1, 32'd333});

    // MT writes
    @(posedge clk); #1;
    start = 1'b1; op = 3'd4; a = 32'h0000_A5A5;
    @(posedge clk); #1;
    start = 1'b0;
    check("mthi_hilo", {hi, lo}, {32'h0000_A5A5, 32'd333});
    check("mthi_flags", 64'({busy, done}), 64'b00);
    @(posedge clk); #1;
    start = 1'b1; op = 3'd5; a = 32'h0000_5A5A;
    @(posedge clk); #1;
    start = 1'b0;
    check("mtlo_hilo", {hi, lo}, {32'h0000_A5A5, 32'h0000_5A5A});

    // flush together with start in IDLE: nothing accepted
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", 64'(busy), 64'd0);
    check("flush_start_hi", 64'(hi), 64'h0000_A5A5);
    @(posedge clk); #1;
    check("flush_start_idle", 64'({busy, done}), 64'b00);

    // Async reset mid-CALC
    @(posedge clk); #1;
    start = 1'b1; op = 3'd1; a = 32'd12345; b = 32'd678;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
    end
    check("pre_rst_busy", 64'(busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy_done", 64'({busy, done}), 64'b00);
    check("arst_hilo", {hi, lo}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", 64'({busy, done}), 64'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
